// File: rtl/cac_uart_transmitter_pkg.sv
// Shared CAC UART definitions: transmitter FSM encoding and the elaboration-time
// helpers (ceil-log2, baud divider) used by both the TX and RX paths.
package cac_uart_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int cac_clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result++;
    end
    return result;
  endfunction

  // Clock cycles per bit, rounded to nearest.
  function automatic int cac_uart_div(input int clk_freq, input int baudrate);
    return (clk_freq + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/cac_uart_transmitter_if.sv
// Write-side handshake and status bundle of the CAC UART transmitter.
interface cac_uart_transmitter_if
  import cac_uart_transmitter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16
);

  localparam int LEVEL_W = cac_clog2(LENGTH) + 1;

  logic               tx_wr_en;
  logic [WIDTH-1:0]   tx_wr_data;
  logic               tx_full;
  logic               tx_empty;
  logic [LEVEL_W-1:0] tx_level;
  logic               tx_busy;
  logic               tx_overflow;

  modport master (
    output tx_wr_en, tx_wr_data,
    input  tx_full, tx_empty, tx_level, tx_busy, tx_overflow
  );

  modport slave (
    input  tx_wr_en, tx_wr_data,
    output tx_full, tx_empty, tx_level, tx_busy, tx_overflow
  );

endinterface

// File: rtl/cac_uart_transmitter_fifo.sv
// Single-clock FIFO with registered full/empty/level flags and an overflow
// pulse; shared by the CAC UART TX and RX paths.
module cac_sync_fifo
  import cac_uart_transmitter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 16,
  localparam int PTR_W   = cac_clog2(LENGTH),
  localparam int LEVEL_W = PTR_W + 1
) (
  input  logic               clk_cac,
  input  logic               rstb_cac,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  logic [WIDTH-1:0]   mem [LENGTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_next;
  logic               do_push;
  logic               do_pop;

  // Full/empty are the pre-cycle flags, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage write.
  // NOTE: the data array is left unreset; pointers and level alone define which
  // entries are valid, and skipping reset keeps the array mappable to RAM.
  always_ff @(posedge clk_cac) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers (wrap naturally at the power-of-two depth), level and flags.
  always_ff @(posedge clk_cac or negedge rstb_cac) begin
    if (!rstb_cac) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_next;
      full     <= (level_next == LEVEL_W'(LENGTH));
      empty    <= (level_next == '0);
      overflow <= push && full;
    end
  end

endmodule

// File: rtl/cac_uart_transmitter.sv
// CAC UART transmitter: FIFO-buffered bytes serialised as start / BITLEN data
// bits LSB first / stop, with back-to-back frames when data is queued.
module cac_uart_transmitter
  import cac_uart_transmitter_pkg::*;
#(
  parameter int CAC_UART_CLK_FREQ      = 10_000_000,
  parameter int CAC_UART_BAUDRATE      = 115200,
  parameter int CAC_UART_BITLEN        = 8,
  parameter int CAC_UART_BUFFER_WIDTH  = 8,
  parameter int CAC_UART_BUFFER_LENGTH = 16
) (
  input  logic                   clk_cac,
  input  logic                   rstb_cac,
  cac_uart_transmitter_if.slave  bus,
  output logic                   uart_tx
);

  localparam int DIV   = cac_uart_div(CAC_UART_CLK_FREQ, CAC_UART_BAUDRATE);
  localparam int CNT_W = cac_clog2(DIV);
  localparam int BIT_W = cac_clog2(CAC_UART_BITLEN);

  tx_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                  baud_q, baud_d;
  logic [BIT_W-1:0]                  bit_q, bit_d;
  logic [CAC_UART_BITLEN-1:0]        shift_q, shift_d;
  logic                              tx_d;
  logic                              pop;
  logic                              fifo_empty;
  logic                              baud_done;
  logic [CAC_UART_BUFFER_WIDTH-1:0]  head;

  cac_sync_fifo #(
    .WIDTH  (CAC_UART_BUFFER_WIDTH),
    .LENGTH (CAC_UART_BUFFER_LENGTH)
  ) u_fifo (
    .clk_cac   (clk_cac),
    .rstb_cac  (rstb_cac),
    .push      (bus.tx_wr_en),
    .push_data (bus.tx_wr_data),
    .pop       (pop),
    .head      (head),
    .full      (bus.tx_full),
    .empty     (fifo_empty),
    .level     (bus.tx_level),
    .overflow  (bus.tx_overflow)
  );

  assign bus.tx_empty = fifo_empty;
  assign bus.tx_busy  = (state_q != ST_IDLE);
  assign baud_done    = (baud_q == CNT_W'(DIV - 1));

  // Next-state, divider, bit counter, shift register and FIFO pop decode.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned (no latches); combinational blocks use blocking '=' while the
  // state registers below use non-blocking '<='.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head[CAC_UART_BITLEN-1:0];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(CAC_UART_BITLEN - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head[CAC_UART_BITLEN-1:0];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Line level for the state being entered, so the uart_tx flop lines up
    // with state_q.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and the uart_tx output flop.
  always_ff @(posedge clk_cac or negedge rstb_cac) begin
    if (!rstb_cac) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      uart_tx <= tx_d;
    end
  end

endmodule

// File: tb/tb_cac_uart_transmitter.sv
// Self-checking bench for cac_uart_transmitter: a cycle-level reference of
// the FIFO and line timing, plus a mid-bit UART receiver scoreboard.
module tb_cac_uart_transmitter;

  localparam int DIV   = 87;            // (10e6 + 57600) / 115200
  localparam int FRAME = 10 * DIV;      // 8N1 frame
  localparam int HALF  = DIV / 2;
  localparam int DEPTH = 16;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  logic uart_tx1;
  logic uart_tx2;

  always #5 clk = ~clk;

  cac_uart_transmitter_if #(.WIDTH(8), .LENGTH(16)) bus1 ();
  cac_uart_transmitter_if #(.WIDTH(8), .LENGTH(16)) bus2 ();

  cac_uart_transmitter dut (
    .clk_cac  (clk),
    .rstb_cac (rstb),
    .bus      (bus1),
    .uart_tx  (uart_tx1)
  );

  cac_uart_transmitter #(.CAC_UART_BITLEN(7)) dut7 (
    .clk_cac  (clk),
    .rstb_cac (rstb),
    .bus      (bus2),
    .uart_tx  (uart_tx2)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (updates on clock edges) ----------------
  int         m_level = 0;
  int         m_frame = 0;     // cycles left in the current frame, 0 = idle
  logic [7:0] m_cur   = 8'h00;
  logic       m_ovf   = 1'b0;
  logic [7:0] m_q[$];          // model FIFO contents
  logic [7:0] sb_q[$];         // bytes expected at the receiver

  initial forever begin
    @(posedge clk or negedge rstb);
    if (!rstb) begin
      m_level = 0;
      m_frame = 0;
      m_ovf   = 1'b0;
      m_q.delete();
      sb_q.delete();
    end else begin
      logic push;
      logic pop;
      logic acc;
      int   lvl;
      push = bus1.tx_wr_en;
      lvl  = m_level;
      pop  = (lvl > 0) && (m_frame == 0 || m_frame == 1);
      acc  = push && (lvl < DEPTH);
      if (pop) begin
        m_cur   = m_q.pop_front();
        m_frame = FRAME;
      end else if (m_frame > 0) begin
        m_frame--;
      end
      m_ovf = push && (lvl == DEPTH);
      if (acc) begin
        m_q.push_back(bus1.tx_wr_data);
        sb_q.push_back(bus1.tx_wr_data);
      end
      m_level = lvl + int'(acc) - int'(pop);
    end
  end

  function automatic logic exp_line();
    int pos;
    int b;
    if (m_frame == 0) return 1'b1;
    pos = FRAME - m_frame;
    b   = pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  // ---------------- per-cycle output checks (mid-cycle) ----------------
  int ovf_seen  = 0;
  int max_level = 0;

  initial forever begin
    @(negedge clk);
    check("uart_tx",  uart_tx1,          exp_line());
    check("level",    bus1.tx_level,     m_level);
    check("empty",    bus1.tx_empty,     m_level == 0);
    check("full",     bus1.tx_full,      m_level == DEPTH);
    check("busy",     bus1.tx_busy,      m_frame != 0);
    check("overflow", bus1.tx_overflow,  m_ovf);
    if (bus1.tx_overflow) ovf_seen++;
    if (int'(bus1.tx_level) > max_level) max_level = int'(bus1.tx_level);
  end

  // ---------------- UART receiver / scoreboard ----------------
  int         rx_count = 0;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  initial forever begin
    @(negedge clk);
    if (!rstb) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx1 == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= HALF && ((rx_cnt - HALF) % DIV) == 0) begin
        int idx;
        idx = (rx_cnt - HALF) / DIV;
        if (idx == 0) begin
          check("rx_start_bit", uart_tx1, 1'b0);
        end else if (idx <= 8) begin
          rx_byte[idx-1] = uart_tx1;
        end else begin
          check("rx_stop_bit", uart_tx1, 1'b1);
          check("rx_sb_pending", sb_q.size() > 0, 1'b1);
          if (sb_q.size() > 0) check("rx_byte", rx_byte, sb_q.pop_front());
          rx_count++;
          rx_active = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic [7:0] d);
    @(negedge clk);
    bus1.tx_wr_en   = en;
    bus1.tx_wr_data = d;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    bit done;
    done = 1'b0;
    drive(1'b0, 8'h00);
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!bus1.tx_busy && bus1.tx_empty) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int         rx0;
    int         ovf0;
    int         lat;
    logic [8:0] exp7;

    bus1.tx_wr_en   = 1'b0;
    bus1.tx_wr_data = 8'h00;
    bus2.tx_wr_en   = 1'b0;
    bus2.tx_wr_data = 8'h00;

    #1 rstb = 1'b0;
    #3;
    check("rst_uart_tx",  uart_tx1,         1'b1);
    check("rst_busy",     bus1.tx_busy,     1'b0);
    check("rst_empty",    bus1.tx_empty,    1'b1);
    check("rst_full",     bus1.tx_full,     1'b0);
    check("rst_level",    bus1.tx_level,    5'd0);
    check("rst_overflow", bus1.tx_overflow, 1'b0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single byte 0xA5
    rx0 = rx_count;
    drive(1'b1, 8'hA5);
    wait_idle("t1_idle", 2000);
    check("t1_rx_count", rx_count - rx0, 1);

    // 2: three consecutive pushes -> contiguous frames
    rx0 = rx_count;
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h55);
    wait_idle("t2_idle", 5000);
    check("t2_rx_count", rx_count - rx0, 3);

    // 3: fill past capacity while the first frame is on the line
    rx0 = rx_count;
    drive(1'b1, 8'h11);
    repeat (4) drive(1'b0, 8'h00);
    ovf0      = ovf_seen;
    max_level = 0;
    for (int i = 0; i < 18; i++) drive(1'b1, 8'(8'h20 + i));
    repeat (3) drive(1'b0, 8'h00);
    check("t3_overflow_pulses", ovf_seen - ovf0, 2);
    check("t3_max_level", max_level, DEPTH);
    wait_idle("t3_idle", 30000);
    check("t3_rx_count", rx_count - rx0, 17);

    // 4: asynchronous reset in the middle of the second queued frame
    rx0 = rx_count;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i));
    drive(1'b0, 8'h00);
    repeat (FRAME + 4 * DIV) @(negedge clk);
    check("t4_busy_before_reset", bus1.tx_busy, 1'b1);
    #2 rstb = 1'b0;
    #1;
    check("t4_rst_uart_tx",  uart_tx1,         1'b1);
    check("t4_rst_busy",     bus1.tx_busy,     1'b0);
    check("t4_rst_empty",    bus1.tx_empty,    1'b1);
    check("t4_rst_full",     bus1.tx_full,     1'b0);
    check("t4_rst_level",    bus1.tx_level,    5'd0);
    check("t4_rst_overflow", bus1.tx_overflow, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (2000) @(negedge clk);
    check("t4_rx_count", rx_count - rx0, 1);

    // 5: 20 spaced pushes, pointers wrap
    rx0       = rx_count;
    max_level = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)));
      repeat (299) drive(1'b0, 8'h00);
    end
    wait_idle("t5_idle", 20000);
    check("t5_rx_count", rx_count - rx0, 20);
    check("t5_level_bounded", max_level <= DEPTH, 1'b1);

    // 6: BITLEN=7 instance, 0x81 -> 0,1,0,0,0,0,0,0,1
    exp7 = 9'b1_0000001_0;        // bit 0 goes on the line first
    @(negedge clk);
    bus2.tx_wr_en   = 1'b1;
    bus2.tx_wr_data = 8'h81;
    @(negedge clk);
    bus2.tx_wr_en   = 1'b0;
    lat = 1;
    while (uart_tx2 !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t6_fall_latency", lat, 2);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t6_bit%0d", k), uart_tx2, exp7[k]);
      if (k < 8) repeat (DIV) @(negedge clk);
    end
    repeat (DIV) @(negedge clk);
    check("t6_busy_done", bus2.tx_busy, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
